// File: rtl/neuromorphic_x1_wb_bridge.sv
// Wishbone-classic slave bridge for the NEUROMORPHIC_X1 macro: window decode, held macro request,
// response timeout, sticky error flag and a local status register.
module neuromorphic_x1_wb_bridge #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK     = 32'hFFFF_0000,
  parameter logic [31:0] STATUS_OFFSET = 32'h0000_FFFC,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] AD,
  output logic [31:0] DI,
  output logic [3:0]  SEL,
  input  logic [31:0] DO,
  input  logic        func_ack
);

  typedef enum logic [2:0] {StIdle, StLocal, StWait, StResp, StDrain} state_e;

  localparam logic [15:0] LastWait = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        en_q, en_d, rwb_q, rwb_d, ack_q, ack_d, err_q, err_d;
  logic [31:0] ad_q, ad_d, di_q, di_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d, txn_q, txn_d;

  logic        hit, done;
  logic [31:0] offset, rdata;

  assign hit    = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign offset = wbs_adr_i & ~ADDR_MASK;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    rwb_d   = rwb_q;
    ad_d    = ad_q;
    di_d    = di_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    dat_d   = 32'h0;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    err_d   = err_q;
    done    = 1'b0;
    rdata   = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i && hit) begin
          if (offset == STATUS_OFFSET) begin
            state_d = StLocal;
            ack_d   = 1'b1;
            if (wbs_we_i) begin
              if (wbs_sel_i[0] && wbs_dat_i[0]) err_d = 1'b0;
            end else begin
              dat_d = {txn_q, 14'b0, 1'b0, err_q};
            end
          end else begin
            state_d = StWait;
            en_d    = 1'b1;
            rwb_d   = ~wbs_we_i;
            ad_d    = offset;
            di_d    = wbs_dat_i;
            sel_d   = wbs_sel_i;
            cnt_d   = 16'h0;
          end
        end
      end
      StWait, StDrain: begin
        // func_ack wins over a timeout landing on the same edge
        if (func_ack) begin
          done  = 1'b1;
          en_d  = 1'b0;
          txn_d = txn_q + 16'd1;
          rdata = rwb_q ? DO : 32'h0;
        end else if (cnt_q == LastWait) begin
          done  = 1'b1;
          en_d  = 1'b0;
          err_d = 1'b1;
          rdata = rwb_q ? 32'hDEAD_BEEF : 32'h0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (done) begin
          // A completion coinciding with a bus abort is finished silently
          if (state_q == StWait && wbs_cyc_i) begin
            state_d = StResp;
            ack_d   = 1'b1;
            dat_d   = rdata;
          end else begin
            state_d = StIdle;
          end
        end else if (state_q == StWait && !wbs_cyc_i) begin
          state_d = StDrain;
        end
      end
      StLocal, StResp: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      rwb_q   <= 1'b0;
      ad_q    <= 32'h0;
      di_q    <= 32'h0;
      sel_q   <= 4'h0;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      cnt_q   <= 16'h0;
      txn_q   <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rwb_q   <= rwb_d;
      ad_q    <= ad_d;
      di_q    <= di_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
    end
  end

  assign EN        = en_q;
  assign R_WB      = rwb_q;
  assign AD        = ad_q;
  assign DI        = di_q;
  assign SEL       = sel_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_neuromorphic_x1_wb_bridge.sv
// Bench for neuromorphic_x1_wb_bridge: directed scenarios plus randomized macro transactions
// checked against a transaction-level model (latency vs. timeout, txn count, sticky error).
module tb_neuromorphic_x1_wb_bridge;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] STAT = 32'h3000_FFFC;

  logic        CLKin = 1'b0;
  logic        RSTin = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        EN, R_WB;
  logic [31:0] AD, DI;
  logic [3:0]  SEL;
  logic [31:0] DO = 32'h0;
  logic        func_ack = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int          txn_m = 0;
  logic        err_m = 1'b0;

  neuromorphic_x1_wb_bridge #(.TIMEOUT(TMO)) dut (
    .CLKin(CLKin), .RSTin(RSTin),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .EN(EN), .R_WB(R_WB), .AD(AD), .DI(DI), .SEL(SEL), .DO(DO), .func_ack(func_ack)
  );

  always #5 CLKin = ~CLKin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one bus cycle from a negedge; the macro acks on its lat-th EN cycle (never if 0 or
  // beyond the timeout). Returns at the negedge of the ack cycle, or after a cycle budget.
  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int lat, input logic [31:0] dov,
                          output logic [31:0] rdat, output int en_cycles, output bit acked);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; DO = dov;
    en_cycles = 0; acked = 0; rdat = 32'h0;
    for (int c = 0; c < 40 && !acked; c++) begin
      @(negedge CLKin);
      if (EN) begin
        en_cycles++;
        check("req_ad", AD, adr & 32'h0000_FFFF);
        check("req_rwb", {31'b0, R_WB}, {31'b0, ~we});
        check("req_di", DI, dat);
        check("req_sel", {28'b0, SEL}, {28'b0, sel});
      end
      func_ack = EN && (en_cycles == lat);
      if (wbs_ack_o) begin
        acked = 1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; func_ack = 1'b0;
  endtask

  task automatic do_macro(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int lat, input logic [31:0] dov);
    logic [31:0] rdat, exp_dat;
    int          en_cycles;
    bit          acked, ok;
    ok      = (lat >= 1) && (lat <= int'(TMO));
    exp_dat = we ? 32'h0 : (ok ? dov : 32'hDEAD_BEEF);
    bus_xfer(we, adr, dat, sel, lat, dov, rdat, en_cycles, acked);
    check("xfer_acked", {31'b0, acked}, 32'd1);
    check("xfer_en_cycles", en_cycles, ok ? lat : TMO);
    check("xfer_rdata", rdat, exp_dat);
    if (ok) txn_m++;
    else err_m = 1'b1;
    @(negedge CLKin);
    check("ack_one_cycle", {31'b0, wbs_ack_o}, 32'd0);
    check("dat_idle_zero", wbs_dat_o, 32'h0);
  endtask

  task automatic status_check(input string tag);
    logic [31:0] rdat;
    int          en_cycles;
    bit          acked;
    bus_xfer(1'b0, STAT, 32'h0, 4'hF, 0, 32'h0, rdat, en_cycles, acked);
    check({tag, "_acked"}, {31'b0, acked}, 32'd1);
    check({tag, "_no_en"}, en_cycles, 0);
    check(tag, rdat, {txn_m[15:0], 15'b0, err_m});
    @(negedge CLKin);
  endtask

  task automatic status_clear();
    logic [31:0] rdat;
    int          en_cycles;
    bit          acked;
    bus_xfer(1'b1, STAT, 32'h1, 4'b0001, 0, 32'h0, rdat, en_cycles, acked);
    check("clear_acked", {31'b0, acked}, 32'd1);
    err_m = 1'b0;
    @(negedge CLKin);
  endtask

  initial begin
    repeat (2) @(negedge CLKin);
    check("rst_en", {31'b0, EN}, 32'd0);
    check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("rst_outs", AD | DI | wbs_dat_o | {28'b0, SEL} | {31'b0, R_WB}, 32'h0);
    RSTin = 1'b0;
    @(negedge CLKin);

    do_macro(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'hCAFE_0001);
    do_macro(1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011, 2, 32'hFFFF_FFFF);
    status_check("status_txn2");
    do_macro(1'b0, 32'h3000_0100, 32'h0, 4'hF, 0, 32'h1111_1111);
    status_check("status_err_set");
    status_clear();
    status_check("status_err_clr");
    do_macro(1'b0, 32'h3000_0200, 32'h0, 4'hF, TMO, 32'h0055_AA00);
    do_macro(1'b0, 32'h3000_0204, 32'h0, 4'hF, 1, 32'h7777_0001);
    status_check("status_ack_wins");

    // Stray func_ack while idle
    func_ack = 1'b1;
    @(negedge CLKin);
    func_ack = 1'b0;
    check("stray_en", {31'b0, EN}, 32'd0);
    @(negedge CLKin);
    check("stray_ack", {31'b0, wbs_ack_o}, 32'd0);
    status_check("status_stray");

    // Out-of-window access is never answered
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h4000_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLKin);
      check("miss_en", {31'b0, EN}, 32'd0);
      check("miss_ack", {31'b0, wbs_ack_o}, 32'd0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge CLKin);

    // Bus abort: EN held until the macro completes, no bus ack
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0020;
    @(negedge CLKin);
    check("abort_en1", {31'b0, EN}, 32'd1);
    @(negedge CLKin);
    check("abort_en2", {31'b0, EN}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      @(negedge CLKin);
      check("abort_en_held", {31'b0, EN}, 32'd1);
      check("abort_no_ack", {31'b0, wbs_ack_o}, 32'd0);
      if (c == 5) func_ack = 1'b1;
    end
    @(negedge CLKin);
    func_ack = 1'b0;
    check("abort_en_drop", {31'b0, EN}, 32'd0);
    check("abort_no_ack_end", {31'b0, wbs_ack_o}, 32'd0);
    @(negedge CLKin);
    check("abort_no_ack_late", {31'b0, wbs_ack_o}, 32'd0);
    txn_m++;
    do_macro(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 32'hABCD_0123);
    status_check("status_after_abort");

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] off;
      off = 32'($urandom_range(0, 32'h3FFE)) << 2;
      do_macro(1'($urandom), 32'h3000_0000 | off, $urandom, 4'($urandom),
               int'($urandom_range(1, 12)), $urandom);
      if ($urandom_range(0, 4) == 0) status_check("status_rand");
      if (err_m && $urandom_range(0, 2) == 0) status_clear();
    end
    status_check("status_rand_end");

    // Reset in the middle of a wait
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h3000_0040;
    wbs_dat_i = 32'hFEED_F00D; wbs_sel_i = 4'hF;
    repeat (2) @(negedge CLKin);
    check("pre_rst_en", {31'b0, EN}, 32'd1);
    RSTin = 1'b1;
    #1;
    check("mid_rst_en", {31'b0, EN}, 32'd0);
    check("mid_rst_outs", AD | DI | wbs_dat_o | {28'b0, SEL} | {31'b0, R_WB | wbs_ack_o},
          32'h0);
    @(negedge CLKin);
    RSTin = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    txn_m = 0; err_m = 1'b0;
    @(negedge CLKin);
    status_check("status_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
